// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches from a combinational imem and
// fills the IF/ID register, with stall, redirect and sticky fetch-error capture.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 1024,
    parameter logic [31:0] NOP        = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] iaddr,
    input  logic [31:0] idata,
    output logic [31:0] pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic [31:0] fetch_count,
    output logic [1:0]  errorbits,
    output logic [31:0] wrongaddr
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_ERR  = 2'd2
    } state_e;

    // 33-bit bound so that IMEM_WORDS*4 == 2^32 cannot overflow the compare.
    localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [1:0]  errorbits_q, errorbits_d;
    logic [31:0] wrongaddr_q, wrongaddr_d;
    logic        pc_oob;

    assign pc_oob = {1'b0, pc_q} >= IMEM_BYTES;

    always_comb begin
        // NOTE: every next-state signal gets a hold default first, so no path
        // through the case below can leave one unassigned and infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        ifid_valid_d  = ifid_valid_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_pc4_d    = ifid_pc4_q;
        fetch_count_d = fetch_count_q;
        errorbits_d   = errorbits_q;
        wrongaddr_d   = wrongaddr_q;

        case (state_q)
            S_BOOT: begin
                ifid_valid_d = 1'b0;
                ifid_instr_d = NOP;
                state_d      = S_RUN;
            end
            S_RUN: begin
                if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                    errorbits_d[0] = 1'b1;
                    wrongaddr_d    = redirect_pc;
                    ifid_valid_d   = 1'b0;
                    ifid_instr_d   = NOP;
                    state_d        = S_ERR;
                end else if (redirect_valid) begin
                    // Redirect flushes even under stall: the stalled slot is on the wrong path.
                    pc_d         = redirect_pc;
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (pc_oob) begin
                    errorbits_d[1] = 1'b1;
                    wrongaddr_d    = pc_q;
                    ifid_valid_d   = 1'b0;
                    ifid_instr_d   = NOP;
                    state_d        = S_ERR;
                end else begin
                    ifid_instr_d  = idata;
                    ifid_pc_d     = pc_q;
                    ifid_pc4_d    = pc_q + 32'd4;
                    ifid_valid_d  = 1'b1;
                    pc_d          = pc_q + 32'd4;
                    fetch_count_d = fetch_count_q + 32'd1;
                end
            end
            S_ERR: begin
                ifid_valid_d = 1'b0;
                ifid_instr_d = NOP;
            end
            default: begin
                state_d      = S_ERR;
                ifid_valid_d = 1'b0;
                ifid_instr_d = NOP;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed above.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            ifid_valid_q  <= 1'b0;
            ifid_instr_q  <= NOP;
            ifid_pc_q     <= 32'd0;
            ifid_pc4_q    <= 32'd0;
            fetch_count_q <= 32'd0;
            errorbits_q   <= 2'b00;
            wrongaddr_q   <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ifid_valid_q  <= ifid_valid_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_pc4_q    <= ifid_pc4_d;
            fetch_count_q <= fetch_count_d;
            errorbits_q   <= errorbits_d;
            wrongaddr_q   <= wrongaddr_d;
        end
    end

    assign iaddr       = pc_q;
    assign pc          = pc_q;
    assign ifid_valid  = ifid_valid_q;
    assign ifid_instr  = ifid_instr_q;
    assign ifid_pc     = ifid_pc_q;
    assign ifid_pc4    = ifid_pc4_q;
    assign fetch_count = fetch_count_q;
    assign errorbits   = errorbits_q;
    assign wrongaddr   = wrongaddr_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: scoreboard of expected fetches plus direct
// checks of reset, stall, redirect, error capture and asynchronous reset.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] iaddr, idata, pc, ifid_instr, ifid_pc, ifid_pc4, fetch_count, wrongaddr;
    logic        ifid_valid;
    logic [1:0]  errorbits;

    // Second instance with a 4-word imem, free-running with no stall/redirect.
    logic        s_stall = 1'b0;
    logic        s_redirect_valid = 1'b0;
    logic [31:0] s_redirect_pc = 32'd0;
    logic [31:0] s_iaddr, s_idata, s_pc, s_ifid_instr, s_ifid_pc, s_ifid_pc4, s_fetch_count, s_wrongaddr;
    logic        s_ifid_valid;
    logic [1:0]  s_errorbits;

    logic [31:0] imem [0:1023];

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    fetch_t exp_q[$];
    int     n_checks = 0;
    int     n_errors = 0;

    always #5 clk = ~clk;

    assign idata   = imem[iaddr[11:2]];
    assign s_idata = imem[s_iaddr[11:2]];

    if_stage #(.RESET_PC(32'h0), .IMEM_WORDS(1024), .NOP(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .iaddr(iaddr), .idata(idata), .pc(pc),
        .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
        .ifid_pc4(ifid_pc4), .fetch_count(fetch_count), .errorbits(errorbits),
        .wrongaddr(wrongaddr)
    );

    if_stage #(.RESET_PC(32'h0), .IMEM_WORDS(4), .NOP(NOP)) dut_small (
        .clk(clk), .rst(rst), .stall(s_stall), .redirect_valid(s_redirect_valid),
        .redirect_pc(s_redirect_pc), .iaddr(s_iaddr), .idata(s_idata), .pc(s_pc),
        .ifid_valid(s_ifid_valid), .ifid_instr(s_ifid_instr), .ifid_pc(s_ifid_pc),
        .ifid_pc4(s_ifid_pc4), .fetch_count(s_fetch_count), .errorbits(s_errorbits),
        .wrongaddr(s_wrongaddr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input logic [31:0] a);
        fetch_t f;
        f.pc    = a;
        f.instr = imem[a[11:2]];
        exp_q.push_back(f);
    endtask

    // Monitor: pop the scoreboard whenever a new instruction enters IF/ID.
    initial begin
        logic [31:0] prev_count;
        fetch_t      f;
        prev_count = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (ifid_valid && fetch_count != prev_count) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_fetch", ifid_pc, 32'hFFFF_FFFF);
                end else begin
                    f = exp_q.pop_front();
                    check("sb_instr", ifid_instr, f.instr);
                    check("sb_pc", ifid_pc, f.pc);
                    check("sb_pc4", ifid_pc4, f.pc + 32'd4);
                end
            end
            prev_count = fetch_count;
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = 32'hC0DE_0000 | 32'(i);
        imem[0] = 32'hAAAA_0001;
        imem[1] = 32'hBBBB_0002;
        imem[2] = 32'hCCCC_0003;
        imem[3] = 32'hDDDD_0004;

        #50;
        check("rst_pc", pc, 32'd0);
        check("rst_valid", {31'd0, ifid_valid}, 32'd0);
        check("rst_instr", ifid_instr, NOP);
        check("rst_ifid_pc", ifid_pc, 32'd0);
        check("rst_pc4", ifid_pc4, 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_err", {30'd0, errorbits}, 32'd0);
        check("rst_wrong", wrongaddr, 32'd0);

        #50 rst = 1'b1;
        tick();
        check("boot_valid", {31'd0, ifid_valid}, 32'd0);
        check("boot_instr", ifid_instr, NOP);
        check("boot_pc", pc, 32'd0);

        for (int i = 0; i < 4; i++) begin
            expect_fetch(32'(i * 4));
            tick();
        end
        check("seq_iaddr", iaddr, 32'd16);
        check("seq_count", fetch_count, 32'd4);
        check("small_pc", s_pc, 32'd16);

        // Edge 6: small instance faults on pc=16; main redirects to 4.
        redirect_valid = 1'b1;
        redirect_pc    = 32'd4;
        tick();
        redirect_valid = 1'b0;
        check("small_err", {30'd0, s_errorbits}, 32'd2);
        check("small_wrong", s_wrongaddr, 32'd16);
        check("small_count", s_fetch_count, 32'd4);
        check("small_valid", {31'd0, s_ifid_valid}, 32'd0);
        check("redir4_valid", {31'd0, ifid_valid}, 32'd0);
        check("redir4_pc", pc, 32'd4);
        check("redir4_count", fetch_count, 32'd4);

        expect_fetch(32'd4);
        tick();
        check("pre_stall_pc", pc, 32'd8);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", pc, 32'd8);
            check("stall_instr", ifid_instr, imem[1]);
            check("stall_ifid_pc", ifid_pc, 32'd4);
            check("stall_count", fetch_count, 32'd5);
        end
        stall = 1'b0;
        expect_fetch(32'd8);
        tick();
        check("post_stall_pc", ifid_pc, 32'd8);
        check("post_stall_instr", ifid_instr, imem[2]);
        check("post_stall_iaddr", iaddr, 32'd12);

        // Redirect coinciding with stall: flush wins.
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        check("rs_valid", {31'd0, ifid_valid}, 32'd0);
        check("rs_instr", ifid_instr, NOP);
        check("rs_pc", pc, 32'h40);
        check("rs_count", fetch_count, 32'd6);
        expect_fetch(32'h40);
        tick();
        check("target_ifid_pc", ifid_pc, 32'h40);
        check("target_count", fetch_count, 32'd7);

        // Asynchronous reset mid-cycle.
        #2 rst = 1'b0;
        #1;
        check("arst_pc", pc, 32'd0);
        check("arst_valid", {31'd0, ifid_valid}, 32'd0);
        check("arst_count", fetch_count, 32'd0);
        #1 rst = 1'b1;
        tick();
        check("reboot_valid", {31'd0, ifid_valid}, 32'd0);
        check("reboot_pc", pc, 32'd0);
        expect_fetch(32'd0);
        tick();
        check("reboot_fetch_pc", pc, 32'd4);

        // Misaligned redirect, then an ignored aligned one.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        tick();
        check("mis_err", {30'd0, errorbits}, 32'd1);
        check("mis_wrong", wrongaddr, 32'h42);
        check("mis_valid", {31'd0, ifid_valid}, 32'd0);
        check("mis_pc", pc, 32'd4);
        redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        check("err_pc", pc, 32'd4);
        check("err_bits", {30'd0, errorbits}, 32'd1);
        check("err_wrong", wrongaddr, 32'h42);
        tick();
        tick();
        check("err_hold_pc", pc, 32'd4);
        check("err_hold_count", fetch_count, 32'd1);
        check("err_hold_valid", {31'd0, ifid_valid}, 32'd0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the CPU_pipe pipeline, directly upstream of decode.
- Owns the program counter and drives iaddr to the combinational imem.
- Registers the fetched word into the IF/ID pipeline register.
- Handles stall and branch/jump redirect from later stages, and flags fetch errors. Those flags feed the core's errorbits/wrongaddr outputs.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_WORDS, 1024, number of 32-bit words in imem; fetch at or beyond IMEM_WORDS*4 is an error
NOP, 32'h0000_0013, instruction injected into IF/ID on flush or reset (addi x0,x0,0)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  reset; asynchronous, active-low (asserted when 0)
stall  input  1  hold PC and IF/ID (load-use hazard from decode)
redirect_valid  input  1  taken branch/jump resolved downstream this cycle
redirect_pc  input  32  target PC for redirect
iaddr  output  32  imem byte address; equals current pc
idata  input  32  imem read data, combinational from iaddr
pc  output  32  current fetch PC (debug)
ifid_valid  output  1  IF/ID register holds a real instruction
ifid_instr  output  32  registered instruction
ifid_pc  output  32  PC of ifid_instr
ifid_pc4  output  32  ifid_pc + 4
fetch_count  output  32  number of instructions accepted into IF/ID
errorbits  output  2  sticky error flags: bit0 misaligned redirect, bit1 out-of-range fetch
wrongaddr  output  32  offending address of the first error

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC, state=S_BOOT, ifid_valid=0, ifid_instr=NOP.
  - ifid_pc=0, ifid_pc4=0, fetch_count=0, errorbits=0, wrongaddr=0.
- iaddr = pc, combinational from the pc register. idata is sampled on the same rising edge.
- State machine has three states, S_BOOT, S_RUN and S_ERR:
  - S_BOOT: first edge after rst release. Bubble only (ifid_valid=0, ifid_instr=NOP). pc unchanged. Next state S_RUN unconditionally; stall and redirect are ignored.
  - S_RUN: each rising edge applies the following in priority order:
    1. redirect_valid=1 and redirect_pc[1:0]!=0: errorbits[0]<=1, wrongaddr<=redirect_pc, ifid flushed to NOP/valid=0, pc held, go S_ERR.
    2. redirect_valid=1, aligned: pc<=redirect_pc, ifid_valid<=0, ifid_instr<=NOP. fetch_count unchanged. The flush wins over a simultaneous stall.
    3. stall=1: pc, ifid_* and fetch_count hold.
    4. pc >= IMEM_WORDS*4: errorbits[1]<=1, wrongaddr<=pc, ifid flushed, go S_ERR.
    5. Normal fetch:
       - ifid_instr<=idata, ifid_pc<=pc, ifid_pc4<=pc+4, ifid_valid<=1.
       - pc<=pc+4, fetch_count<=fetch_count+1.
  - S_ERR: terminal until reset.
    - pc, errorbits and wrongaddr frozen.
    - ifid_valid=0, ifid_instr=NOP.
    - stall and redirect are ignored.
- Arithmetic widths:
  - pc+4 is 32-bit modulo 2^32. Wrap to 0 is legal arithmetic but is caught by rule 4 first when IMEM_WORDS*4 < 2^32.
  - fetch_count is 32-bit and wraps.
- Only the first error is recorded: errorbits is set once, wrongaddr is written once.
- Branch penalty is 1 bubble: the instruction on the redirect edge is discarded. The target is fetched on the next edge.
- Reset asserted mid-operation: all state returns to reset values immediately, independent of clk.

Test Plan:
- Release rst at t=100ns with RESET_PC=0 and imem[0..3]=A,B,C,D:
  - edge 1 (S_BOOT): ifid_valid=0.
  - edges 2-5: ifid_instr=A,B,C,D with ifid_pc=0,4,8,12; iaddr=16 after edge 5; fetch_count=4.
- With pc=8, assert stall for 3 cycles: pc stays 8; ifid_instr/ifid_pc unchanged; fetch_count unchanged. Release: next edge fetches imem[2] with ifid_pc=8.
- At pc=12, pulse redirect_valid with redirect_pc=0x40 and stall=1 simultaneously:
  - next edge: ifid_valid=0, ifid_instr=0x00000013, pc=0x40.
  - following edge: ifid_pc=0x40.
- Pulse redirect_pc=0x42: errorbits=2'b01, wrongaddr=0x42, ifid_valid stays 0. A further aligned redirect to 0x0 is ignored (pc stays at the pre-redirect value).
- With IMEM_WORDS=4, run sequentially from 0: after fetching pc=12, the edge at pc=16 sets errorbits=2'b10, wrongaddr=16, fetch_count=4.
- Assert rst=0 asynchronously mid-cycle in S_RUN: pc=0, ifid_valid=0 and fetch_count=0 before the next clk edge. Release: the S_BOOT bubble is repeated.
